// File: rtl/sp_mem_pkg.sv
// Shared types, bounds and helpers for the sp_mem_ctrl single-port memory.
package sp_mem_pkg;

  typedef enum logic {CLEAR, RUN} state_t;

  localparam int RD_LAT_MIN = 1;
  localparam int RD_LAT_MAX = 4;

  function automatic int lane_count(input int data_w);
    return data_w / 8;
  endfunction

  // Even parity: the stored bit makes the total number of ones even.
  function automatic logic byte_parity(input logic [7:0] b);
    return ^b;
  endfunction

endpackage

// File: rtl/sp_mem_ctrl_if.sv
// Request/response bus of sp_mem_ctrl; par_err exists only with SP_MEM_CTRL_PARITY_EN.
interface sp_mem_ctrl_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 16
);
  logic                  req_valid;
  logic                  req_ready;
  logic                  req_we;
  logic [DATA_W/8-1:0]   req_be;
  logic [ADDR_W-1:0]     req_addr;
  logic [DATA_W-1:0]     req_wdata;
  logic                  rsp_valid;
  logic [DATA_W-1:0]     rsp_rdata;
`ifdef SP_MEM_CTRL_PARITY_EN
  logic                  par_err;
`endif

  modport master (
    output req_valid, req_we, req_be, req_addr, req_wdata,
`ifdef SP_MEM_CTRL_PARITY_EN
    input  par_err,
`endif
    input  req_ready, rsp_valid, rsp_rdata
  );

  modport slave (
    input  req_valid, req_we, req_be, req_addr, req_wdata,
`ifdef SP_MEM_CTRL_PARITY_EN
    output par_err,
`endif
    output req_ready, rsp_valid, rsp_rdata
  );

endinterface

// File: rtl/sp_mem_rd_pipe.sv
// RD_LAT-stage read response shift register; only the valid bits are reset.
module sp_mem_rd_pipe #(
  parameter int DATA_W = 32,
  parameter int RD_LAT = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_err,
  output logic              out_valid,
  output logic [DATA_W-1:0] out_data,
  output logic              out_err
);

  logic [RD_LAT-1:0] valid_q;
  logic [RD_LAT-1:0] err_q;
  logic [DATA_W-1:0] data_q [RD_LAT];

  // NOTE: sequential state uses non-blocking assignments so every stage samples the pre-edge value of its neighbour.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      valid_q <= '0;
    end else begin
      valid_q[0] <= in_valid;
      for (int i = 1; i < RD_LAT; i++) valid_q[i] <= valid_q[i-1];
    end
  end

  // Payload needs no reset: it is only observed while the matching valid bit is set.
  always_ff @(posedge clk) begin
    data_q[0] <= in_data;
    err_q[0]  <= in_err;
    for (int i = 1; i < RD_LAT; i++) begin
      data_q[i] <= data_q[i-1];
      err_q[i]  <= err_q[i-1];
    end
  end

  assign out_valid = valid_q[RD_LAT-1];
  assign out_data  = data_q[RD_LAT-1];
  assign out_err   = err_q[RD_LAT-1];

endmodule

// File: rtl/sp_mem_ctrl.sv
// Single-port memory with valid/ready requests, byte enables, RD_LAT read pipe and post-reset clear.
// Optional per-byte even parity is enabled by defining SP_MEM_CTRL_PARITY_EN.
module sp_mem_ctrl
  import sp_mem_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 16,
  parameter int DEPTH  = 65536,
  parameter int RD_LAT = 1
) (
  input  logic           clk,
  input  logic           rst,
  sp_mem_ctrl_if.slave   bus,
  output logic           init_busy
);

  localparam int                LANES     = lane_count(DATA_W);
  localparam int                IDX_W     = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [ADDR_W:0]   DEPTH_LIM = (ADDR_W + 1)'(DEPTH);
  localparam logic [IDX_W-1:0]  LAST_IDX  = IDX_W'(DEPTH - 1);

  if (DATA_W % 8 != 0) begin : g_bad_data_w
    $error("sp_mem_ctrl: DATA_W must be a multiple of 8");
  end
  if (DEPTH > 2 ** ADDR_W) begin : g_bad_depth
    $error("sp_mem_ctrl: DEPTH exceeds the address space");
  end
  if (RD_LAT < RD_LAT_MIN || RD_LAT > RD_LAT_MAX) begin : g_bad_rd_lat
    $error("sp_mem_ctrl: RD_LAT out of range");
  end

  state_t            state_q, state_d;
  logic [IDX_W-1:0]  clr_cnt_q, clr_cnt_d;
  logic              ready;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= CLEAR;
      clr_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      clr_cnt_q <= clr_cnt_d;
    end
  end

  // NOTE: every combinational output gets a default first so no path can infer a latch.
  always_comb begin
    state_d   = state_q;
    clr_cnt_d = clr_cnt_q;
    ready     = 1'b0;
    init_busy = 1'b0;
    case (state_q)
      CLEAR: begin
        init_busy = 1'b1;
        if (clr_cnt_q == LAST_IDX) state_d = RUN;
        else                       clr_cnt_d = clr_cnt_q + IDX_W'(1);
      end
      RUN: ready = 1'b1;
    endcase
  end

  assign bus.req_ready = ready;

  logic             accept, in_range, rd_fire;
  logic [IDX_W-1:0] idx;

  assign accept   = bus.req_valid && ready;
  assign in_range = {1'b0, bus.req_addr} < DEPTH_LIM;
  assign idx      = bus.req_addr[IDX_W-1:0];
  assign rd_fire  = accept && !bus.req_we;

  // The clear walk and the request port share the single write port.
  logic              wr_en;
  logic [IDX_W-1:0]  wr_idx;
  logic [DATA_W-1:0] wr_data;
  logic [LANES-1:0]  wr_be;

  always_comb begin
    wr_en   = 1'b0;
    wr_idx  = idx;
    wr_data = bus.req_wdata;
    wr_be   = bus.req_be;
    if (state_q == CLEAR) begin
      wr_en   = 1'b1;
      wr_idx  = clr_cnt_q;
      wr_data = '0;
      wr_be   = '1;
    end else begin
      wr_en   = accept && bus.req_we && in_range;
    end
  end

  logic [DATA_W-1:0] mem [DEPTH];

  // NOTE: the array is deliberately not reset; the CLEAR walk gives it defined contents.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      for (int i = 0; i < LANES; i++)
        if (wr_be[i]) mem[wr_idx][i*8 +: 8] <= wr_data[i*8 +: 8];
    end
  end

  logic [DATA_W-1:0] rd_word;
  logic              rd_err;

  assign rd_word = in_range ? mem[idx] : '0;

`ifdef SP_MEM_CTRL_PARITY_EN
  logic [LANES-1:0] par_mem [DEPTH];

  always_ff @(posedge clk) begin
    if (wr_en) begin
      for (int i = 0; i < LANES; i++)
        if (wr_be[i]) par_mem[wr_idx][i] <= byte_parity(wr_data[i*8 +: 8]);
    end
  end

  always_comb begin
    rd_err = 1'b0;
    if (in_range) begin
      for (int i = 0; i < LANES; i++)
        if (byte_parity(rd_word[i*8 +: 8]) != par_mem[idx][i]) rd_err = 1'b1;
    end
  end
`else
  assign rd_err = 1'b0;
`endif

  logic              pipe_valid, pipe_err;
  logic [DATA_W-1:0] pipe_data;

  sp_mem_rd_pipe #(
    .DATA_W (DATA_W),
    .RD_LAT (RD_LAT)
  ) u_rd_pipe (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (rd_fire),
    .in_data   (rd_word),
    .in_err    (rd_err),
    .out_valid (pipe_valid),
    .out_data  (pipe_data),
    .out_err   (pipe_err)
  );

  assign bus.rsp_valid = pipe_valid;
  assign bus.rsp_rdata = pipe_valid ? pipe_data : '0;

`ifdef SP_MEM_CTRL_PARITY_EN
  assign bus.par_err = pipe_valid && pipe_err;
`else
  logic unused_pipe_err;
  assign unused_pipe_err = pipe_err;
`endif

endmodule
